uart_rx: RTL
============

# uart_rx

Serial UART receiver: the stage directly downstream of the `hello_world` transmitter's `tx` line. Recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) from an asynchronous `rx` input, presents each byte on `data` with a one-cycle `valid` strobe, and flags bad stop bits. Used as the loopback checker for serial transmit blocks and as the receive half of the serial link.

## Interface
- `CLOCKS_PER_BIT`, default 10: clock cycles per bit period. Must be ≥ 4; odd values use floor(CLOCKS_PER_BIT/2) for the half-bit wait.
- `clk` in, 1 bit: the single clock; all logic on posedge.
- `rst` in, 1 bit: synchronous, active-low reset (reset when `rst == 0` at posedge).
- `rx` in, 1 bit: serial line, idle high, asynchronous to `clk`.
- `data` out, 8 bits: last correctly received byte; held until the next good frame.
- `valid` out, 1 bit: one-cycle pulse, `data` newly updated.
- `frame_error` out, 1 bit: one-cycle pulse, stop bit sampled low.
- `busy` out, 1 bit: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s1`, `rx_s2`), reset to 1. The FSM uses `rx_s2` only.
- Bit counter `cnt` has width $clog2(CLOCKS_PER_BIT). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits, shifted right with the new bit entering at bit 7.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rx_s2 == 0`, go to START and set `cnt` = 0.
- START: count to CLOCKS_PER_BIT/2 − 1 (mid start bit), then sample.
  - If `rx_s2 == 0`: go to DATA with `cnt` = 0 and `idx` = 0.
  - Otherwise (glitch): return to IDLE with no output activity.
- DATA: count to CLOCKS_PER_BIT − 1, then sample `rx_s2` into `sh`.
  - If `idx == 7`: go to STOP with `cnt` = 0.
  - Otherwise: increment `idx` and set `cnt` = 0.
- STOP: count to CLOCKS_PER_BIT − 1, then sample.
  - If 1: `data` ← `sh`, pulse `valid`, go to IDLE.
  - If 0: pulse `frame_error`, leave `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s2 == 1`, then go to IDLE. A held-low (break) line therefore produces exactly one `frame_error` and never a `valid`.
- IDLE is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit (back-to-back frames) is caught.
- `valid` and `frame_error` are never high together.

## Timing
- Reset values:
  - `data` = 8'h00, `valid` = 0, `frame_error` = 0, `busy` = 0.
  - State IDLE, `cnt` = 0, `idx` = 0, `sh` = 0, synchronizer flops = 1.
- Reset mid-frame: the receiver is in IDLE on the next cycle. The remainder of the aborted frame must not produce `valid`. Its low data bits may be taken as a new start bit, which ends in `frame_error` or garbage, as the line dictates.
- Latency: let cycle 0 be the first posedge at which `rx_s1` captures the low start bit. Then:
  - START is entered at posedge 2.
  - The data bit k sample is taken at posedge 2 + CLOCKS_PER_BIT/2 + (k+1)·CLOCKS_PER_BIT.
  - The stop sample is taken at posedge 2 + CLOCKS_PER_BIT/2 + 9·CLOCKS_PER_BIT.
  - `valid` / `frame_error` are high for the cycle following that posedge.
  - With CLOCKS_PER_BIT = 10, the strobe follows posedge 97.
- Sampling tolerance: sampling at mid-bit tolerates about ±4% baud mismatch over a frame.
- `busy` rises the cycle after IDLE→START and falls the cycle after leaving STOP or WAIT_HIGH.

## Test plan
- **Single byte:** CLOCKS_PER_BIT = 10; send 0x48 ('H') at 10 clocks/bit after reset release → one `valid` pulse at the computed latency, `data` = 0x48, `frame_error` never high.
- **Back-to-back frames:** send 0x65 then 0x6C with no idle gap → two `valid` pulses exactly 100 cycles apart, `data` = 0x65 then 0x6C.
- **Glitch:** drive `rx` low for 3 cycles, then high → no `valid`, no `frame_error`, `busy` returns low within 8 cycles.
- **Bad stop bit:** send 0xA5 with stop bit 0, then a valid 0x3C → one `frame_error`, `data` stays at its prior value; then `valid` with `data` = 0x3C.
- **Break and recovery:** hold `rx` low for 300 cycles, release, then send 0x55 → exactly one `frame_error`, then `valid` with 0x55.
- **Loopback and reset:** connect to the `hello_world` `tx` output and trigger it → the received byte sequence equals the transmitted message with no errors. Separately, assert `rst` low for 1 cycle mid-byte → all outputs return to reset values on the next cycle, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte out with valid/frame_error strobes.
// Latency: strobe is high the cycle after the stop sample, 2 + CPB/2 + 9*CPB posedges after rx_s1 sees the start edge.
// Backpressure: none; valid is a one-cycle pulse and data holds until the next good frame.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic          rx_s1_q, rx_s1_d;
    logic          rx_s2_q, rx_s2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;

    always_comb begin
        rx_s1_d = rx;
        rx_s2_d = rx_s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A start bit that is no longer low at its midpoint was a glitch.
                    if (!rx_s2_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (rx_s2_q) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != S_IDLE);

endmodule
